// File: rtl/sr_latch_driver_pkg.sv
// Shared types and limits for the SR latch driver.
// Holds the FSM state enum, counter width and legal parameter ranges.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } sr_state_e;

    localparam int CNT_W = 4;

    localparam int PULSE_W_MIN = 1;
    localparam int PULSE_W_MAX = 15;
    localparam int SETTLE_MIN  = 0;
    localparam int SETTLE_MAX  = 15;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command/latch interface of the SR latch driver; dbg_state mirrors the FSM.
// req_valid/req_ready: a command transfers on a rising edge where both are high.
interface sr_latch_driver_if;
    import sr_pkg::*;

    logic      req_valid;
    logic      req_level;
    logic      req_ready;
    logic      s;
    logic      r;
    logic      q_fb;
    logic      busy;
    logic      done;
    logic      err;
    logic      level;
    sr_state_e dbg_state;

    modport master (
        output req_valid, req_level, q_fb,
        input  req_ready, s, r, busy, done, err, level, dbg_state
    );

    modport slave (
        input  req_valid, req_level, q_fb,
        output req_ready, s, r, busy, done, err, level, dbg_state
    );

endinterface

// File: rtl/sr_latch_driver.sv
// Drives s/r of a NOR SR latch with width-controlled, mutually exclusive pulses.
// Define SR_VERIFY_EN to compare latch readback in CHECK and raise a sticky err.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus
);

    if (PULSE_W < PULSE_W_MIN || PULSE_W > PULSE_W_MAX) begin : g_bad_pulse_w
        $error("sr_latch_driver: PULSE_W out of range 1..15");
    end
    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("sr_latch_driver: SETTLE out of range 0..15");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    sr_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tgt;
    logic             r_s;
    logic             r_r;
    logic             r_done;
    logic             r_err;
    logic             r_level;
    logic             r_ready;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tgt   <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_level <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_tgt   <= bus.req_level;
                        r_level <= bus.req_level;
                        r_cnt   <= PULSE_LOAD;
                        // s and r are complementary here, so never both high.
                        r_s     <= bus.req_level;
                        r_r     <= ~bus.req_level;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_s <= 1'b0;
                        r_r <= 1'b0;
                        if (SETTLE > 0) begin
                            r_cnt   <= SETTLE_LOAD;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_CHECK: begin
`ifdef SR_VERIFY_EN
                    if (bus.q_fb != r_tgt) begin
                        r_err <= 1'b1;
                    end
`endif
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.s         = r_s;
    assign bus.r         = r_r;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.level     = r_level;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous controller that drives the s/r inputs of a cross-coupled NOR SR latch.
- Turns a handshaked "set level" command into a clean, width-controlled set or reset pulse.
- Guarantees s and r are never both high, so the latch never enters the forbidden state.
- Optionally reads back the latch q output to confirm the commanded level was stored.

Parameters:
- PULSE_W, 2, cycles s or r is held high per command; legal range 1..15
- SETTLE, 2, cycles both s and r are held low after the pulse, before readback; legal range 0..15

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  command present
- req_level  input  1  target latch level: 1 = set, 0 = reset
- req_ready  output  1  high only in IDLE; command accepted when req_valid && req_ready
- s  output  1  set drive to latch, registered
- r  output  1  reset drive to latch, registered
- q_fb  input  1  latch q readback; used only when SR_VERIFY_EN is defined
- busy  output  1  high while a command is in progress (state != IDLE)
- done  output  1  one-cycle pulse when a command completes
- err  output  1  sticky readback-mismatch flag
- level  output  1  last commanded level, updated when a command is accepted

Behaviour:
- One clock domain; reset is synchronous and active-high. Port names are clk and rst.
- Reset values: state=IDLE, s=0, r=0, done=0, err=0, level=0, req_ready=1, busy=0.
- FSM states: IDLE, PULSE, SETTLE, CHECK. All outputs are registered.
- IDLE:
  - On accept, latch tgt=req_level, set level=req_level, load cnt=PULSE_W-1, go to PULSE.
  - At the same edge, s<=tgt and r<=~tgt.
- PULSE:
  - Hold s/r. Decrement cnt each cycle.
  - When cnt==0: s<=0, r<=0.
    - If SETTLE>0: load cnt=SETTLE-1, go to SETTLE.
    - Otherwise: go to CHECK.
- SETTLE: s=r=0. Decrement cnt; when cnt==0, go to CHECK.
- CHECK (one cycle):
  - Sample q_fb and compare with tgt.
  - Pulse done=1 at the next edge and go to IDLE.
- Timing:
  - Accept at edge k → s or r high for exactly PULSE_W cycles starting k.
  - Then SETTLE cycles with both low, then one CHECK cycle.
  - done is high in the cycle after CHECK.
  - req_ready is low for PULSE_W+SETTLE+1 cycles.
- Invariants:
  - s&&r is never 1 in any cycle, including reset exit and mid-command reset.
  - A command with the same level as the current one still issues a full pulse (refresh).
- Boundaries:
  - req_valid while busy: ignored; the requester holds it until req_ready.
  - Back-to-back commands: a new command may be accepted in the same cycle done is high, because the state is IDLE.
  - rst asserted mid-command: s and r go to 0 at that edge and the command is discarded with no done.
  - req_level is sampled only at accept; later changes have no effect.

Optional Feature:
- Macro SR_VERIFY_EN.
- Defined:
  - CHECK compares q_fb against tgt.
  - On mismatch, err<=1 and stays high until rst.
  - done still pulses.
- Undefined:
  - q_fb is unused and err is tied to 0.
  - CHECK still takes one cycle, so timing is identical.

Decomposition:
- Shared package sr_pkg holds:
  - state enum (IDLE, PULSE, SETTLE, CHECK)
  - CNT_W=4 constant
  - PULSE_W/SETTLE range limits, for elaboration-time assertions
- No sub-module needed; a single FSM plus a shared down-counter.
- The bench instantiates the existing NOR SR latch as the load, with q wired to q_fb.

Test Plan:
- Reset, then idle for 5 cycles → s=r=0, req_ready=1, level=0, err=0, done=0 throughout.
- Defaults, req_level=1 accepted at cycle 10 → s=1 in cycles 10-11; s=r=0 in 12-13; CHECK at 14; done=1 in 15; latch q=1; err=0.
- Set then immediately reset, req_valid held high → second command accepted in the done cycle; r=1 for 2 cycles; q=0; s and r never both high.
- rst pulsed during the second PULSE cycle → s drops at that edge; no done; level=0; next command runs normally.
- SR_VERIFY_EN defined, q_fb forced to 0 on a set command → err=1 after CHECK and stays set across further commands until rst.
- PULSE_W=1, SETTLE=0 → s high for 1 cycle, CHECK next cycle, done 2 cycles after accept.
